// File: rtl/data_mem_responder.sv
// Word-organised data memory with a single-outstanding valid/ready request
// port, fixed response latency, RV32I sub-word loads/stores and error flagging.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [0:DEPTH-1];

    logic                  enter_resp;
    logic                  eff_we;
    logic [31:0]           eff_addr;
    logic [31:0]           eff_wdata;
    logic [2:0]            eff_f3;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            off;
    logic [31:0]           word;
    logic [31:0]           merged;
    logic [31:0]           load_val;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic                  acc_err;
    logic                  unused_addr_hi;

    // With LATENCY=1 the access happens on the acceptance edge itself, before
    // the request has been captured, so the live request inputs are used then.
    always_comb begin
        if (state == IDLE) begin
            eff_we    = req_we;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_f3    = req_funct3;
        end else begin
            eff_we    = we_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_f3    = f3_q;
        end
    end

    assign idx            = eff_addr[ADDR_WIDTH+1:2];
    assign off            = eff_addr[1:0];
    assign word           = mem[idx];
    assign unused_addr_hi = ^eff_addr[31:ADDR_WIDTH+2];

    always_comb begin
        acc_err = 1'b0;
        case (eff_f3)
            3'b000, 3'b100: acc_err = eff_we & eff_f3[2];
            3'b001, 3'b101: acc_err = off[0] | (eff_we & eff_f3[2]);
            3'b010:         acc_err = |off;
            default:        acc_err = 1'b1;
        endcase
    end

    always_comb begin
        lane_b = word[7:0];
        case (off)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];

        load_val = '0;
        case (eff_f3)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_val = {24'b0, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_val = {16'b0, lane_h};
            3'b010:  load_val = word;
            default: load_val = '0;
        endcase
        if (eff_we || acc_err) begin
            load_val = '0;
        end
    end

    always_comb begin
        merged = word;
        case (eff_f3[1:0])
            2'b00:   merged[{off, 3'b000} +: 8]     = eff_wdata[7:0];
            2'b01:   merged[{off[1], 4'b0000} +: 16] = eff_wdata[15:0];
            2'b10:   merged = eff_wdata;
            default: merged = word;
        endcase
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset wins over the transition, so a store pending in WAIT never commits.
    assign enter_resp = !rst && (state != RESP) && (state_nx == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                cnt     <= LAT_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= load_val;
                err_q   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && eff_we && !acc_err) begin
            mem[idx] <= merged;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder, checked against a
// byte-addressed reference model of the memory and access rules.
module tb_data_mem_responder;

    localparam int ADDR_WIDTH = 5;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int NBYTES     = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mb [0:NBYTES-1];

    data_mem_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: RV32I access rules on a byte array.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
        int size;
        int b;
        logic [31:0] v;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << int'(f3[1:0]);
        b     = int'(addr % NBYTES);
        rd    = '0;
        er    = 1'b0;
        if (!legal || (addr % size) != 0) begin
            er = 1'b1;
        end else if (we) begin
            for (int k = 0; k < size; k++) mb[b + k] = 8'(wdata >> (8 * k));
        end else begin
            v = '0;
            for (int k = 0; k < size; k++) v = v | (32'(mb[b + k]) << (8 * k));
            if (f3[2] == 1'b0 && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat, output bit to);
        int n;
        to  = 1'b0;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        rsp_ready  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            to = 1'b1;
            return;
        end
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin
            to = 1'b1;
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_init();
        logic [31:0] rd, erd, d;
        logic er, eer;
        int lat;
        bit to;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            xact(1'b1, 32'(i * 4), d, 3'b010, rd, er, lat, to);
            model_access(1'b1, 32'(i * 4), d, 3'b010, erd, eer);
            checks++; if (to) begin errors++; $display("FAIL init_timeout: word %0d no response", i); end
            checks++; if (er !== eer || rd !== erd) begin errors++; $display("FAIL init_store: word %0d got err=%b rd=%h want err=%b rd=%h", i, er, rd, eer, erd); end
            checks++; if (lat != LATENCY) begin errors++; $display("FAIL init_latency: got %0d want %0d", lat, LATENCY); end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        er;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[15];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to;
        tbl = '{
            '{1'b1, 32'h08, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0},
            '{1'b0, 32'h08, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
            '{1'b1, 32'h09, 32'h00000080, 3'b000, 32'h0, 1'b0},
            '{1'b0, 32'h08, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0},
            '{1'b0, 32'h09, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0},
            '{1'b0, 32'h09, 32'h0,        3'b100, 32'h00000080, 1'b0},
            '{1'b0, 32'h0A, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0},
            '{1'b0, 32'h0A, 32'h0,        3'b101, 32'h0000DEAD, 1'b0},
            '{1'b0, 32'h0A, 32'h0,        3'b010, 32'h0, 1'b1},
            '{1'b1, 32'h0B, 32'h00001234, 3'b001, 32'h0, 1'b1},
            '{1'b0, 32'h08, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0},
            '{1'b0, 32'h88, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0},
            '{1'b0, 32'hFFFFFF8B, 32'h0,  3'b000, 32'hFFFFFFDE, 1'b0},
            '{1'b0, 32'h08, 32'h0,        3'b011, 32'h0, 1'b1},
            '{1'b1, 32'h08, 32'h0,        3'b100, 32'h0, 1'b1}
        };
        for (int i = 0; i < 15; i++) begin
            xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, er, lat, to);
            model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, erd, eer);
            checks++; if (to) begin errors++; $display("FAIL dir_timeout: step %0d", i); end
            checks++; if (rd !== tbl[i].rd) begin errors++; $display("FAIL dir_rdata: step %0d got %h want %h", i, rd, tbl[i].rd); end
            checks++; if (er !== tbl[i].er) begin errors++; $display("FAIL dir_err: step %0d got %b want %b", i, er, tbl[i].er); end
            checks++; if (lat != LATENCY) begin errors++; $display("FAIL dir_latency: step %0d got %0d want %0d", i, lat, LATENCY); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d;
        logic er, eer, we;
        logic [2:0] f3;
        int lat;
        bit to;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            xact(we, a, d, f3, rd, er, lat, to);
            model_access(we, a, d, f3, erd, eer);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout: op %0d", i); end
            checks++; if (rd !== erd || er !== eer) begin errors++; $display("FAIL rand_rsp: op %0d we=%b f3=%0d a=%h got rd=%h err=%b want rd=%h err=%b", i, we, f3, a, rd, er, erd, eer); end
            checks++; if (lat != LATENCY) begin errors++; $display("FAIL rand_latency: op %0d got %0d want %0d", i, lat, LATENCY); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, n;
        bit to;
        model_access(1'b0, 32'h08, 32'h0, 3'b010, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08; req_funct3 = 3'b010; req_wdata = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (!rsp_valid) begin errors++; $display("FAIL bp_timeout: rsp_valid got 0 want 1"); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h55555555; req_funct3 = 3'b010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: cycle %0d got %b want 1", c, rsp_valid); end
            checks++; if (rsp_rdata !== erd || rsp_err !== eer) begin errors++; $display("FAIL bp_data_stable: cycle %0d got %h/%b want %h/%b", c, rsp_rdata, rsp_err, erd, eer); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: cycle %0d got %b want 0", c, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_req: cycle %0d rsp_valid got %b want 0", c, rsp_valid); end
        end
        xact(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lat, to);
        model_access(1'b0, 32'h08, 32'h0, 3'b010, erd, eer);
        checks++; if (to || rd !== erd || er !== eer) begin errors++; $display("FAIL bp_mem_unchanged: got %h/%b want %h/%b", rd, er, erd, eer); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'h11111111; req_funct3 = 3'b010;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rw_in_wait: valid=%b ready=%b want 0/0", rsp_valid, req_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_idle_after_rst: req_ready got %b want 1", req_ready); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_no_rsp: cycle %0d got %b want 0", c, rsp_valid); end
            @(negedge clk);
        end
        xact(1'b0, 32'h0C, 32'h0, 3'b010, rd, er, lat, to);
        model_access(1'b0, 32'h0C, 32'h0, 3'b010, erd, eer);
        checks++; if (to || rd !== erd || er !== eer) begin errors++; $display("FAIL rw_store_dropped: got %h/%b want %h/%b", rd, er, erd, eer); end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd, erd, d;
        logic er, eer;
        int lat, n;
        bit to;
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = d; req_funct3 = 3'b010;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++; if (!rsp_valid) begin errors++; $display("FAIL rr_timeout: rsp_valid got 0 want 1"); end
        model_access(1'b1, 32'h10, d, 3'b010, erd, eer);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rr_dropped: valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rr_rsp_cleared: got %h/%b want 0/0", rsp_rdata, rsp_err); end
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, to);
        model_access(1'b0, 32'h10, 32'h0, 3'b010, erd, eer);
        checks++; if (to || rd !== erd || er !== eer) begin errors++; $display("FAIL rr_store_kept: got %h/%b want %h/%b", rd, er, erd, eer); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08; req_wdata = '0; req_funct3 = 3'b010;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && acc.size() < 3; c++) begin
            if (req_ready) acc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (acc.size() != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] != LATENCY + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc[i] - acc[i-1], LATENCY + 1); end
        end
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        checks++; if (!req_ready) begin errors++; $display("FAIL b2b_drain: req_ready got 0 want 1"); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; rsp_ready = 1'b0;
        test_reset();
        test_init();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_wait();
        test_reset_resp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
